// File: rtl/m_d_flit_assembler_pkg.sv
// Shared widths, flit control codes and assembler FSM encodings for the
// memory-to-data-cache flit assembler.
package m_d_flit_assembler_pkg;

    localparam int FLIT_W    = 16;
    localparam int MAX_FLITS = 9;
    localparam int MSG_W     = FLIT_W * MAX_FLITS;
    localparam int CNT_W     = 4;

    typedef enum logic [1:0] {
        FLIT_NONE = 2'b00,
        FLIT_HEAD = 2'b01,
        FLIT_BODY = 2'b10,
        FLIT_TAIL = 2'b11
    } flit_ctrl_e;

    typedef enum logic [1:0] {
        ASM_IDLE    = 2'b00,
        ASM_COLLECT = 2'b01,
        ASM_HOLD    = 2'b10,
        ASM_WAIT    = 2'b11
    } asm_state_e;

endpackage

// File: rtl/m_d_flit_slot_wr.sv
// Combinational insert of one flit into the message register at a slot index;
// slot 0 is the most significant flit, out-of-range indices leave it unchanged.
module m_d_flit_slot_wr
    import m_d_flit_assembler_pkg::*;
(
    input  logic [MSG_W-1:0]  msg_in,
    input  logic [FLIT_W-1:0] flit,
    input  logic [CNT_W-1:0]  idx,
    output logic [MSG_W-1:0]  msg_out
);

    always_comb begin
        msg_out = msg_in;
        for (int i = 0; i < MAX_FLITS; i++) begin
            if (idx == CNT_W'(i)) begin
                msg_out[MSG_W-1-FLIT_W*i -: FLIT_W] = flit;
            end
        end
    end

endmodule

// File: rtl/m_d_flit_assembler.sv
// Collects ring flits of one memory reply into a 144-bit message and issues it
// as a single-cycle strobe once the downstream argument register is idle.
module m_d_flit_assembler
    import m_d_flit_assembler_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] flit_in,
    input  logic              v_flit_in,
    input  logic [1:0]        ctrl_in,
    input  logic              m_d_areg_state,
    output logic              flit_in_ready,
    output logic [MSG_W-1:0]  m_flits_d,
    output logic              v_m_flits_d,
    output logic              asm_overflow,
    output logic [1:0]        asm_state
);

    asm_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [MSG_W-1:0] msg_q, msg_d;
    logic             v_q, v_d;
    logic             ovf_q, ovf_d;

    flit_ctrl_e       ctrl;
    logic             acc;
    logic [MSG_W-1:0] wr_base;
    logic [CNT_W-1:0] wr_idx;
    logic [MSG_W-1:0] wr_msg;

    assign ctrl          = flit_ctrl_e'(ctrl_in);
    assign flit_in_ready = (state_q == ASM_IDLE) || (state_q == ASM_COLLECT);
    assign acc           = v_flit_in && flit_in_ready && (ctrl != FLIT_NONE);

    // A head always starts from an empty message at slot 0.
    assign wr_base = (ctrl == FLIT_HEAD) ? '0 : msg_q;
    assign wr_idx  = (ctrl == FLIT_HEAD) ? '0 : count_q;

    m_d_flit_slot_wr u_slot_wr (
        .msg_in  (wr_base),
        .flit    (flit_in),
        .idx     (wr_idx),
        .msg_out (wr_msg)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        msg_d   = msg_q;
        v_d     = 1'b0;
        ovf_d   = ovf_q;
        case (state_q)
            ASM_IDLE: begin
                if (acc && ctrl == FLIT_HEAD) begin
                    msg_d   = wr_msg;
                    count_d = CNT_W'(1);
                    state_d = ASM_COLLECT;
                end
            end
            ASM_COLLECT: begin
                if (acc && ctrl == FLIT_HEAD) begin
                    msg_d   = wr_msg;
                    count_d = CNT_W'(1);
                end else if (acc) begin
                    // Beyond the last slot the flit is dropped and flagged.
                    if (count_q < CNT_W'(MAX_FLITS)) begin
                        msg_d = wr_msg;
                        if (ctrl == FLIT_BODY) begin
                            count_d = count_q + CNT_W'(1);
                        end
                    end else begin
                        ovf_d = 1'b1;
                    end
                    if (ctrl == FLIT_TAIL) begin
                        state_d = ASM_HOLD;
                    end
                end
            end
            ASM_HOLD: begin
                if (!m_d_areg_state) begin
                    v_d     = 1'b1;
                    state_d = ASM_WAIT;
                end
            end
            ASM_WAIT: begin
                // Busy is registered downstream, so wait to see it before rearming.
                if (m_d_areg_state) begin
                    msg_d   = '0;
                    count_d = '0;
                    state_d = ASM_IDLE;
                end
            end
            default: state_d = ASM_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ASM_IDLE;
            count_q <= '0;
            msg_q   <= '0;
            v_q     <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            msg_q   <= msg_d;
            v_q     <= v_d;
            ovf_q   <= ovf_d;
        end
    end

    assign m_flits_d    = msg_q;
    assign v_m_flits_d  = v_q;
    assign asm_overflow = ovf_q;
    assign asm_state    = state_q;

endmodule

// File: tb/tb_m_d_flit_assembler.sv
// Directed scoreboard bench for m_d_flit_assembler: messages are pushed as
// expected 144-bit words when sent and popped when the issue strobe appears.
module tb_m_d_flit_assembler;

    logic         clk = 1'b0;
    logic         rst;
    logic [15:0]  flit_in;
    logic         v_flit_in;
    logic [1:0]   ctrl_in;
    logic         m_d_areg_state;
    logic         flit_in_ready;
    logic [143:0] m_flits_d;
    logic         v_m_flits_d;
    logic         asm_overflow;
    logic [1:0]   asm_state;

    int           n_assert = 0;
    int           n_fail   = 0;
    logic [143:0] exp_q[$];
    logic [15:0]  flits[16];
    int           n_flits;

    always #5 clk = ~clk;

    m_d_flit_assembler dut (
        .clk            (clk),
        .rst            (rst),
        .flit_in        (flit_in),
        .v_flit_in      (v_flit_in),
        .ctrl_in        (ctrl_in),
        .m_d_areg_state (m_d_areg_state),
        .flit_in_ready  (flit_in_ready),
        .m_flits_d      (m_flits_d),
        .v_m_flits_d    (v_m_flits_d),
        .asm_overflow   (asm_overflow),
        .asm_state      (asm_state)
    );

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] ctrl, input logic [15:0] data);
        v_flit_in = 1'b1;
        ctrl_in   = ctrl;
        flit_in   = data;
        step();
        v_flit_in = 1'b0;
        ctrl_in   = 2'b00;
        flit_in   = 16'h0;
    endtask

    // Sends flits[0..n_flits-1] as head/bodies/tail and records the expected message.
    task automatic sendMessage();
        logic [143:0] exp;
        exp = '0;
        for (int i = 0; i < n_flits; i++) begin
            if (i == 0)                applyStimulus(2'b01, flits[i]);
            else if (i == n_flits - 1) applyStimulus(2'b11, flits[i]);
            else                       applyStimulus(2'b10, flits[i]);
            if (i < 9) exp[143-16*i -: 16] = flits[i];
        end
        exp_q.push_back(exp);
    endtask

    task automatic expectStrobe(input string tag);
        logic [143:0] exp;
        checkOutput({tag, "_strobe"}, 144'(v_m_flits_d), 144'(1));
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            checkOutput({tag, "_msg"}, m_flits_d, exp);
        end else begin
            checkOutput({tag, "_queue_empty"}, 144'(exp_q.size()), 144'(1));
        end
    endtask

    // Downstream reports busy for one cycle, letting WAIT return to IDLE.
    task automatic releaseWait(input string tag);
        m_d_areg_state = 1'b1;
        step();
        m_d_areg_state = 1'b0;
        checkOutput({tag, "_idle"}, 144'(asm_state), 144'(0));
        checkOutput({tag, "_clr"}, m_flits_d, 144'(0));
        checkOutput({tag, "_ready"}, 144'(flit_in_ready), 144'(1));
    endtask

    initial begin
        rst            = 1'b1;
        flit_in        = 16'h0;
        v_flit_in      = 1'b0;
        ctrl_in        = 2'b00;
        m_d_areg_state = 1'b0;
        step();
        step();
        rst = 1'b0;
        checkOutput("rst_state", 144'(asm_state), 144'(0));
        checkOutput("rst_valid", 144'(v_m_flits_d), 144'(0));
        checkOutput("rst_ovf", 144'(asm_overflow), 144'(0));
        checkOutput("rst_ready", 144'(flit_in_ready), 144'(1));
        checkOutput("rst_msg", m_flits_d, 144'(0));

        // Full 9-flit message with downstream idle: strobe two cycles after tail.
        for (int i = 0; i < 9; i++) flits[i] = 16'hA000 + 16'(i);
        n_flits = 9;
        sendMessage();
        checkOutput("m9_t1_valid", 144'(v_m_flits_d), 144'(0));
        checkOutput("m9_t1_state", 144'(asm_state), 144'(2));
        checkOutput("m9_t1_ready", 144'(flit_in_ready), 144'(0));
        step();
        expectStrobe("m9");
        step();
        checkOutput("m9_one_cycle", 144'(v_m_flits_d), 144'(0));
        checkOutput("m9_wait_state", 144'(asm_state), 144'(3));
        releaseWait("m9");

        // Body in IDLE is dropped.
        applyStimulus(2'b10, 16'hDEAD);
        checkOutput("drop_body_state", 144'(asm_state), 144'(0));
        checkOutput("drop_body_msg", m_flits_d, 144'(0));

        // 3-flit message, low slots zero.
        flits[0] = 16'h1111; flits[1] = 16'h2222; flits[2] = 16'h3333;
        n_flits = 3;
        sendMessage();
        step();
        expectStrobe("m3");
        step();
        releaseWait("m3");

        // Downstream busy across the tail: hold for 20 cycles, then single strobe.
        m_d_areg_state = 1'b1;
        flits[0] = 16'h4444; flits[1] = 16'h5555; flits[2] = 16'h6666; flits[3] = 16'h7777;
        n_flits = 4;
        sendMessage();
        for (int i = 0; i < 20; i++) begin
            checkOutput("hold_valid", 144'(v_m_flits_d), 144'(0));
            checkOutput("hold_ready", 144'(flit_in_ready), 144'(0));
            checkOutput("hold_stable", m_flits_d, exp_q[0]);
            step();
        end
        m_d_areg_state = 1'b0;
        step();
        expectStrobe("hold");

        // Busy late: areg stays 0 in WAIT, no second strobe, heads refused.
        step();
        checkOutput("wait_no_double", 144'(v_m_flits_d), 144'(0));
        checkOutput("wait_state", 144'(asm_state), 144'(3));
        applyStimulus(2'b01, 16'hBEEF);
        checkOutput("wait_no_double2", 144'(v_m_flits_d), 144'(0));
        checkOutput("wait_head_refused", 144'(asm_state), 144'(3));
        checkOutput("wait_ready", 144'(flit_in_ready), 144'(0));
        releaseWait("late_busy");

        // Head mid-collection restarts the message.
        applyStimulus(2'b01, 16'h0101);
        applyStimulus(2'b10, 16'h0202);
        flits[0] = 16'hC000; flits[1] = 16'hC001; flits[2] = 16'hC002;
        n_flits = 3;
        sendMessage();
        step();
        expectStrobe("restart");
        step();
        releaseWait("restart");

        // 11-flit message overflows; only slots 0-8 are issued.
        checkOutput("pre_ovf", 144'(asm_overflow), 144'(0));
        for (int i = 0; i < 11; i++) flits[i] = 16'hB000 + 16'(i);
        n_flits = 11;
        sendMessage();
        checkOutput("ovf_flag", 144'(asm_overflow), 144'(1));
        checkOutput("ovf_state", 144'(asm_state), 144'(2));
        step();
        expectStrobe("ovf");
        step();
        releaseWait("ovf");
        checkOutput("ovf_sticky", 144'(asm_overflow), 144'(1));

        // Reset after 4 of 6 flits discards the partial message.
        applyStimulus(2'b01, 16'hD000);
        applyStimulus(2'b10, 16'hD001);
        applyStimulus(2'b10, 16'hD002);
        applyStimulus(2'b10, 16'hD003);
        checkOutput("mid_collect", 144'(asm_state), 144'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("mid_rst_state", 144'(asm_state), 144'(0));
        checkOutput("mid_rst_valid", 144'(v_m_flits_d), 144'(0));
        checkOutput("mid_rst_msg", m_flits_d, 144'(0));
        checkOutput("mid_rst_ovf", 144'(asm_overflow), 144'(0));
        for (int i = 0; i < 6; i++) flits[i] = 16'hE000 + 16'(i);
        n_flits = 6;
        sendMessage();
        step();
        expectStrobe("post_rst");
        step();
        releaseWait("post_rst");

        checkOutput("queue_drained", 144'(exp_q.size()), 144'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/m_d_flit_assembler.md
Name: m_d_flit_assembler

Overview:
- Ring-side transmitter that feeds the memory-to-data-cache argument register.
- Collects 16-bit ring flits of one memory reply into a 144-bit message (up to 9 flits).
- Issues the message as a one-cycle m_flits_d / v_m_flits_d pulse, only while the argument register reports idle (state 0).
- Back-pressures the ring input while a completed message is waiting to be issued.

Parameters:
- FLIT_W, 16, ring flit width in bits
- MAX_FLITS, 9, flits per message; MSG_W = FLIT_W*MAX_FLITS = 144
- CNT_W, 4, flit counter width; must satisfy 2^CNT_W > MAX_FLITS

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- flit_in  input  16  ring flit data
- v_flit_in  input  1  flit_in valid; accepted only when flit_in_ready=1
- ctrl_in  input  2  flit type: 2'b01 head, 2'b10 body, 2'b11 tail, 2'b00 invalid (ignored)
- m_d_areg_state  input  1  downstream register busy (1) / idle (0)
- flit_in_ready  output  1  assembler can accept a flit this cycle
- m_flits_d  output  144  assembled message, flit 0 in [143:128], unused low flits zero
- v_m_flits_d  output  1  one-cycle issue strobe
- asm_overflow  output  1  sticky: a message exceeded MAX_FLITS
- asm_state  output  2  current FSM state, debug

Behaviour:
- One clock domain. Reset is synchronous and active-high on rst. All regs are updated on posedge clk.
- Reset values:
  - FSM = IDLE, count = 0, message reg = 0.
  - v_m_flits_d = 0, asm_overflow = 0, flit_in_ready = 1.
- Accept condition: acc = v_flit_in & flit_in_ready & (ctrl_in != 2'b00).
- States (2-bit encoding):
  - IDLE (00): ready = 1.
    - acc with head: clear message reg, write flit at slot 0, count = 1, go to COLLECT.
    - acc with body or tail: dropped; asm_overflow unaffected.
    - head+tail single-flit message is not supported: a tail requires a preceding head.
  - COLLECT (01): ready = 1.
    - acc with body: write slot[count], count += 1.
    - acc with tail: write slot[count], go to HOLD.
    - acc with head: restart; message reg cleared, head written at slot 0, count = 1.
    - count == MAX_FLITS and a further body/tail arrives: flit discarded, asm_overflow set.
      - On tail in this case, go to HOLD with the 9 flits already stored.
  - HOLD (10): ready = 0.
    - If m_d_areg_state == 0: drive v_m_flits_d = 1 for this cycle, with m_flits_d = message reg; go to WAIT.
    - Otherwise stay in HOLD; the message is held stable.
  - WAIT (11): ready = 0, v_m_flits_d = 0.
    - Stay until m_d_areg_state == 1, then clear message reg and count, and go to IDLE.
    - WAIT exists because the downstream busy flag is registered: it rises one cycle after the strobe. This prevents a double issue.
- Output timing:
  - v_m_flits_d is a registered output. It is asserted the cycle after HOLD samples m_d_areg_state == 0, and is high for exactly one cycle.
  - m_flits_d is driven from the message reg. It is valid while v_m_flits_d = 1 and stays stable until the return to IDLE.
- Latency:
  - Tail accepted at cycle T gives the earliest strobe at T+2, when downstream is idle.
  - The next head can be accepted the cycle after busy is seen in WAIT.
- Slot write: slot i occupies bits [MSG_W-1-FLIT_W*i -: FLIT_W].
- rst takes priority in every state, including mid-collection and during the strobe. The partial message is discarded and the strobe is deasserted next cycle.
- asm_overflow is cleared only by rst.

Decomposition:
- Shared package holds:
  - flit ctrl encodings (FLIT_HEAD/BODY/TAIL/NONE)
  - FSM state encodings (ASM_IDLE/COLLECT/HOLD/WAIT)
  - FLIT_W, MAX_FLITS, MSG_W
- One natural sub-module: m_d_flit_slot_wr, the combinational slot-insert of a flit into the 144-bit register by index.
- FSM, counter and handshake stay in the top module.

Test Plan:
- Reset, then a 9-flit message (head 16'hA000, bodies A001..A007, tail A008) with m_d_areg_state=0 -> v_m_flits_d high exactly 1 cycle, 2 cycles after the tail; m_flits_d = A000_A001_..._A008.
- 3-flit message (head 16'h1111, body 16'h2222, tail 16'h3333) -> m_flits_d = {16'h1111, 16'h2222, 16'h3333, 96'h0}.
- m_d_areg_state held at 1 for 20 cycles after the tail -> no strobe, flit_in_ready=0, m_flits_d stable; state drops to 0 -> single strobe next cycle.
- Busy rises one cycle after the strobe with state held 0 during the WAIT cycle -> no second strobe; the next message is accepted only after busy is seen.
- 11-flit message (head, 9 bodies, tail) -> asm_overflow=1, slots 0-8 issued, flits 9-10 discarded.
- rst asserted after 4 of 6 flits -> next cycle: FSM IDLE, v_m_flits_d=0, message reg 0; a following full message assembles cleanly.
